// File: rtl/conv_pkg.sv
// Shared types and defaults for the 1D convolution scheduler.
package conv_pkg;

  // Controller states; the encoding is visible on the debug port.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_X = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4,
    OUT    = 3'd5
  } state_t;

  localparam int N_IN_DEF    = 16;
  localparam int K_DEF       = 4;
  localparam int MAC_LAT_DEF = 3;

  // Number of valid-convolution outputs for an n_in-sample input and k taps.
  function automatic int calc_n_out(input int n_in, input int k);
    return n_in - k + 1;
  endfunction

endpackage

// File: rtl/tap_delay_line.sv
// Carries {issue, first} for each issued tap down a LAT-deep pipe so the
// accumulator strobes line up with the product arriving from the multiplier.
module tap_delay_line #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  input  logic first,
  output logic acc_load,
  output logic acc_en,
  output logic pending
);

  logic [LAT-1:0] issue_sr;
  logic [LAT-1:0] first_sr;

  // Shift register; cleared asynchronously so an abort drops every in-flight tap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_sr <= '0;
      first_sr <= '0;
    end else begin
      issue_sr[0] <= issue;
      first_sr[0] <= issue & first;
      for (int k = 1; k < LAT; k++) begin
        issue_sr[k] <= issue_sr[k-1];
        first_sr[k] <= first_sr[k-1];
      end
    end
  end

  assign acc_load = issue_sr[LAT-1] & first_sr[LAT-1];
  assign acc_en   = issue_sr[LAT-1] & ~first_sr[LAT-1];

  // A tap is still pending while it sits in any stage before the output stage.
  always_comb begin
    pending = 1'b0;
    for (int k = 0; k < LAT - 1; k++) begin
      pending = pending | issue_sr[k];
    end
  end

endmodule

// File: rtl/conv1d_sched.sv
// Scheduler for a 1D valid convolution: streams kernel and samples into the
// shared memories, then walks one output window at a time through the MAC.
//
// Handshakes: a beat transfers on a rising clk edge where valid and ready are
// both high. valid, once raised by a producer, is not made to depend on ready;
// output_valid is held with a stable out_idx until output_ready is seen.
module conv1d_sched
  import conv_pkg::*;
#(
  parameter  int N_IN    = N_IN_DEF,
  parameter  int K       = K_DEF,
  parameter  int MAC_LAT = MAC_LAT_DEF,
  localparam int N_OUT   = calc_n_out(N_IN, K),
  localparam int AW_X    = $clog2(N_IN),
  localparam int AW_W    = $clog2(K),
  localparam int OW      = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            input_valid,
  output logic            input_ready,
  input  logic            new_kernel,
  output logic            wr_en_w,
  output logic            wr_en_x,
  output logic [AW_W-1:0] addr_w,
  output logic [AW_X-1:0] addr_x,
  output logic            acc_load,
  output logic            acc_en,
  output logic            output_valid,
  input  logic            output_ready,
  output logic [OW-1:0]   out_idx,
  output logic            busy,
  output state_t          state_dbg
);

  state_t          state_q, state_d;
  logic            kernel_loaded_q, kernel_loaded_d;
  logic [AW_X-1:0] cnt_q, cnt_d;
  logic [OW-1:0]   i_q, i_d;
  logic [AW_W-1:0] j_q, j_d;
  logic            issue, first, pending;

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      kernel_loaded_q <= 1'b0;
      cnt_q           <= '0;
      i_q             <= '0;
      j_q             <= '0;
    end else begin
      state_q         <= state_d;
      kernel_loaded_q <= kernel_loaded_d;
      cnt_q           <= cnt_d;
      i_q             <= i_d;
      j_q             <= j_d;
    end
  end

  // Next state, counters and all strobes/addresses.
  always_comb begin
    state_d         = state_q;
    kernel_loaded_d = kernel_loaded_q;
    cnt_d           = cnt_q;
    i_d             = i_q;
    j_d             = j_q;
    input_ready     = 1'b0;
    wr_en_w         = 1'b0;
    wr_en_x         = 1'b0;
    addr_w          = '0;
    addr_x          = '0;
    issue           = 1'b0;
    first           = 1'b0;
    output_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        input_ready = 1'b1;
        if (input_valid) begin
          // The first beat decides whether a kernel precedes the samples.
          if (new_kernel || !kernel_loaded_q) begin
            wr_en_w = 1'b1;
            state_d = LOAD_W;
          end else begin
            wr_en_x = 1'b1;
            state_d = LOAD_X;
          end
          cnt_d = AW_X'(1);
        end
      end
      LOAD_W: begin
        input_ready = 1'b1;
        addr_w      = cnt_q[AW_W-1:0];
        if (input_valid) begin
          wr_en_w = 1'b1;
          if (cnt_q == AW_X'(K - 1)) begin
            kernel_loaded_d = 1'b1;
            cnt_d           = '0;
            state_d         = LOAD_X;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD_X: begin
        input_ready = 1'b1;
        addr_x      = cnt_q;
        if (input_valid) begin
          wr_en_x = 1'b1;
          if (cnt_q == AW_X'(N_IN - 1)) begin
            cnt_d   = '0;
            i_d     = '0;
            j_d     = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        // One tap per cycle; the highest sample address is N_IN-1.
        addr_w = j_q;
        addr_x = AW_X'(i_q) + AW_X'(j_q);
        issue  = 1'b1;
        first  = (j_q == '0);
        if (j_q == AW_W'(K - 1)) begin
          state_d = DRAIN;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DRAIN: begin
        // Once only the output stage can hold a tap, the sum is complete next cycle.
        if (!pending) begin
          state_d = OUT;
        end
      end
      OUT: begin
        output_valid = 1'b1;
        if (output_ready) begin
          if (i_q == OW'(N_OUT - 1)) begin
            state_d = IDLE;
          end else begin
            i_d     = i_q + 1'b1;
            j_d     = '0;
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  tap_delay_line #(
    .LAT(MAC_LAT)
  ) u_taps (
    .clk     (clk),
    .reset   (reset),
    .issue   (issue),
    .first   (first),
    .acc_load(acc_load),
    .acc_en  (acc_en),
    .pending (pending)
  );

  assign out_idx   = i_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule
